// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch sequencer.
// Pure definitions; no latency or flow control.
package stopwatch_pkg;

  localparam logic [5:0] MAX_SEC = 6'd59;
  localparam logic [5:0] MAX_MIN = 6'd59;

  localparam logic SEL_SEC = 1'b1;
  localparam logic SEL_MIN = 1'b0;

  typedef enum logic {
    RUN,
    PAUSED
  } state_t;

  // Saturating fields are never wanted here: every count field wraps to zero.
  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button/switch inputs and display-side outputs of the stopwatch sequencer.
// Level/pulse signals only; no handshake, the display never stalls the count.
interface stopwatch_ctrl_if;

  logic       pause_btn;
  logic       clr_btn;
  logic       adj;
  logic       sel;
  logic [5:0] min;
  logic [5:0] sec;
  logic       scan_en;
  logic       blink_en;
  logic       paused;

  modport master (
    output pause_btn, clr_btn, adj, sel,
    input  min, sec, scan_en, blink_en, paused
  );

  modport slave (
    input  pause_btn, clr_btn, adj, sel,
    output min, sec, scan_en, blink_en, paused
  );

endinterface

// File: rtl/clk_en_div.sv
// Clock-enable divider: one-cycle registered strobe every DIV cycles.
// Strobe lands the cycle after count DIV-1; clr restarts the period like reset.
module clk_en_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic en
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
      en  <= 1'b0;
    end else begin
      en  <= (cnt == LAST);
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/pause/clear/adjust policy over a mm:ss count plus display strobes.
// Count updates one cycle after its internal tick; all outputs registered, no backpressure.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIV_1HZ   = 100_000_000,
  parameter int unsigned DIV_ADJ   = 50_000_000,
  parameter int unsigned DIV_SCAN  = 100_000,
  parameter int unsigned DIV_BLINK = 25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  io
);

  state_t     state;
  logic       paused_q;
  logic       sel_q;
  logic [5:0] min_q;
  logic [5:0] sec_q;
  logic       tick_1hz;
  logic       tick_adj;
  logic       clr_1hz;
  logic       clr_adj;

  // Holding a divider cleared while its ticks are ignored means the period
  // restarts exactly on resume, on leaving adjust, and on entering adjust.
  assign clr_1hz = (state == PAUSED) | io.adj;
  assign clr_adj = ~io.adj | (io.sel != sel_q);

  clk_en_div #(.DIV(DIV_1HZ))   u_div_1hz   (.clk(clk), .rst(rst), .clr(clr_1hz), .en(tick_1hz));
  clk_en_div #(.DIV(DIV_ADJ))   u_div_adj   (.clk(clk), .rst(rst), .clr(clr_adj), .en(tick_adj));
  clk_en_div #(.DIV(DIV_SCAN))  u_div_scan  (.clk(clk), .rst(rst), .clr(1'b0),    .en(io.scan_en));
  clk_en_div #(.DIV(DIV_BLINK)) u_div_blink (.clk(clk), .rst(rst), .clr(1'b0),    .en(io.blink_en));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      paused_q <= 1'b0;
      sel_q    <= SEL_MIN;
      min_q    <= '0;
      sec_q    <= '0;
    end else begin
      sel_q <= io.sel;
      if (io.pause_btn) begin
        state    <= (state == RUN) ? PAUSED : RUN;
        paused_q <= (state == RUN);
      end
      // Increment decisions use the pre-pulse state, so RUN+pause still counts once.
      if (io.clr_btn) begin
        min_q <= '0;
        sec_q <= '0;
      end else if (io.adj) begin
        if (tick_adj && (io.sel == sel_q)) begin
          if (io.sel == SEL_SEC) sec_q <= wrap_inc(sec_q, MAX_SEC);
          else                   min_q <= wrap_inc(min_q, MAX_MIN);
        end
      end else if ((state == RUN) && tick_1hz) begin
        sec_q <= wrap_inc(sec_q, MAX_SEC);
        if (sec_q == MAX_SEC) min_q <= wrap_inc(min_q, MAX_MIN);
      end
    end
  end

  assign io.min    = min_q;
  assign io.sec    = sec_q;
  assign io.paused = paused_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with shortened dividers (8/4/2/3).
// Inputs change and outputs are sampled on the falling edge.
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(
    .DIV_1HZ(8),
    .DIV_ADJ(4),
    .DIV_SCAN(2),
    .DIV_BLINK(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int m, input int s);
    chk({tag, "_min"}, 32'(sw.min), 32'(m));
    chk({tag, "_sec"}, 32'(sw.sec), 32'(s));
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    sw.pause_btn = 1'b0;
    sw.clr_btn   = 1'b0;
    sw.adj       = 1'b0;
    sw.sel       = SEL_MIN;
    cyc(3);

    // Reset values
    chk_time("rst", 0, 0);
    chk("rst_paused", 32'(sw.paused), 0);
    chk("rst_scan", 32'(sw.scan_en), 0);
    chk("rst_blink", 32'(sw.blink_en), 0);

    // Free run: first tick strobe 8 cycles after release, count one cycle later
    rst = 1'b0;
    cyc(8);
    chk_time("first_tick_pre", 0, 0);
    cyc(1);
    chk_time("first_tick", 0, 1);
    for (int t = 2; t <= 61; t++) begin
      cyc(8);
      chk("run_count", 32'(sw.min) * 60 + 32'(sw.sec), 32'(t));
      chk("run_paused", 32'(sw.paused), 0);
    end
    chk_time("run_61", 1, 1);

    // Adjust minutes: 01 -> 59, wrap to 00 with seconds untouched, back to 59
    sw.adj = 1'b1;
    sw.sel = SEL_MIN;
    cyc(233);
    chk_time("adj_min59", 59, 1);
    cyc(4);
    chk_time("adj_min_wrap", 0, 1);
    cyc(236);
    chk_time("adj_min_back", 59, 1);

    // Adjust seconds: sel change restarts the adjust period
    sw.sel = SEL_SEC;
    cyc(230);
    chk_time("adj_sec58", 59, 58);
    cyc(4);
    chk_time("adj_sec59", 59, 59);
    cyc(4);
    chk_time("adj_sec_wrap", 59, 0);
    cyc(4);
    chk_time("adj_sec1", 59, 1);
    cyc(228);
    chk_time("preload", 59, 58);

    // Leave adjust at 59:58; run to 59:59 then 00:00
    sw.adj = 1'b0;
    cyc(8);
    chk_time("post_adj_hold", 59, 58);
    cyc(1);
    chk_time("to_5959", 59, 59);
    cyc(8);
    chk_time("to_0000", 0, 0);

    // Run to 12:30 then pause
    cyc(6000);
    chk_time("at_1230", 12, 30);
    sw.pause_btn = 1'b1;
    cyc(1);
    sw.pause_btn = 1'b0;
    chk("pause_on", 32'(sw.paused), 1);
    chk_time("pause_now", 12, 30);
    cyc(100);
    chk_time("pause_hold", 12, 30);
    chk("pause_still", 32'(sw.paused), 1);
    sw.pause_btn = 1'b1;
    cyc(1);
    sw.pause_btn = 1'b0;
    chk("resume", 32'(sw.paused), 0);
    cyc(8);
    chk_time("resume_pre", 12, 30);
    cyc(1);
    chk_time("resume_tick", 12, 31);

    // Clear, then run to 05:07 and clear on the same cycle as a tick
    sw.clr_btn = 1'b1;
    cyc(1);
    sw.clr_btn = 1'b0;
    chk_time("clr", 0, 0);
    cyc(2455);
    chk_time("at_0507", 5, 7);
    cyc(7);
    sw.clr_btn = 1'b1;
    cyc(1);
    sw.clr_btn = 1'b0;
    chk_time("clr_vs_tick", 0, 0);

    // Pause pulse coincident with a tick while running
    cyc(24);
    chk_time("at_0003", 0, 3);
    cyc(7);
    sw.pause_btn = 1'b1;
    cyc(1);
    sw.pause_btn = 1'b0;
    chk_time("pause_vs_tick", 0, 4);
    chk("pause_vs_tick_p", 32'(sw.paused), 1);
    cyc(10);
    chk_time("pause_vs_tick_hold", 0, 4);

    // Adjust while paused to 33:44, then reset mid-adjust
    sw.adj = 1'b1;
    sw.sel = SEL_MIN;
    cyc(134);
    chk_time("adj_min33", 33, 4);
    sw.sel = SEL_SEC;
    cyc(162);
    chk_time("adj_3344", 33, 44);
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk_time("mid_adj_rst", 0, 0);
    chk("mid_adj_rst_p", 32'(sw.paused), 0);
    chk("mid_adj_rst_scan", 32'(sw.scan_en), 0);
    chk("mid_adj_rst_blink", 32'(sw.blink_en), 0);

    // Free-running strobes after release: scan every 2, blink every 3
    rst    = 1'b0;
    sw.adj = 1'b0;
    sw.sel = SEL_MIN;
    for (int k = 1; k <= 12; k++) begin
      cyc(1);
      chk("scan_en", 32'(sw.scan_en), (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("blink_en", 32'(sw.blink_en), (k % 3 == 0) ? 32'd1 : 32'd0);
      if (k == 8) chk_time("rst_tick_pre", 0, 0);
      if (k == 9) chk_time("rst_tick", 0, 1);
    end
    chk("rst_run", 32'(sw.paused), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
